serial_capture_buffer: RTL and testbench

- Parametrised serial-to-parallel capture buffer: samples one serial bit per qualified cycle into a DEPTH x WIDTH storage array.
- Supports arm/abort control, done/busy status and random-access word readback.
- Sits between the input-pin sampling logic and the output mux of the top-level tile; readback drives the dedicated outputs.

---
 rtl/serial_capture_buffer_pkg.sv | 8 +
 rtl/serial_capture_buffer_if.sv | 21 ++
 rtl/serial_capture_trigger.sv | 32 +++
 rtl/serial_capture_buffer.sv | 81 ++++++++
 tb/tb_serial_capture_buffer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/serial_capture_buffer_pkg.sv
// serial_capture_pkg: shared FSM state encoding and bit-count sizing for the capture buffer
package serial_capture_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  localparam int STATE_W = 2;
  function automatic int bc_width(input int width, input int depth);
    return $clog2(width * depth) + 1;
  endfunction
endpackage

// File: rtl/serial_capture_buffer_if.sv
// serial_capture_buffer_if: control, serial input, status and readback bundle of the capture buffer
interface serial_capture_buffer_if #(parameter int WIDTH = 8, parameter int DEPTH = 8);
  import serial_capture_pkg::*;
  localparam int AW = $clog2(DEPTH);
  localparam int BCW = bc_width(WIDTH, DEPTH);
  logic ena;
  logic sin;
  logic sin_valid;
  logic arm;
  logic abort;
  logic [WIDTH-1:0] trig_pattern;
  logic [AW-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic busy;
  logic done;
  logic [BCW-1:0] bit_count;
  modport master (output ena, sin, sin_valid, arm, abort, trig_pattern, rd_addr,
                  input rd_data, busy, done, bit_count);
  modport slave (input ena, sin, sin_valid, arm, abort, trig_pattern, rd_addr,
                 output rd_data, busy, done, bit_count);
endinterface

// File: rtl/serial_capture_trigger.sv
// serial_capture_trigger: serial history shifter that flags a start-pattern match once a full word has arrived
module serial_capture_trigger #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift,
  input  logic             sin,
  input  logic [WIDTH-1:0] pattern,
  output logic             match
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-2:0] hist;
  logic [WIDTH-1:0] hist_nxt;
  logic [CW-1:0] cnt;
  logic full;
  // the incoming bit completes the WIDTH-bit window, so the oldest stored bit never needs keeping
  assign hist_nxt = {hist, sin};
  assign full = cnt == CW'(WIDTH - 1);
  assign match = full && hist_nxt == pattern;
  // shift history (newest in LSB) and count received bits up to WIDTH-1, restart on arm
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hist <= '0;
      cnt <= '0;
    end else if (clear) begin
      hist <= '0;
      cnt <= '0;
    end else if (shift) begin
      hist <= hist_nxt[WIDTH-2:0];
      cnt <= full ? cnt : cnt + CW'(1);
    end
endmodule

// File: rtl/serial_capture_buffer.sv
// serial_capture_buffer: serial-to-parallel capture into DEPTH x WIDTH storage; SERIAL_CAPTURE_TRIGGER_EN adds start-pattern arming
module serial_capture_buffer
  import serial_capture_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst_n,
  serial_capture_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(WIDTH);
  localparam int BCW = bc_width(WIDTH, DEPTH);
  localparam int TOTAL = WIDTH * DEPTH;
  state_t state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic idle_or_done, go, cap_we, last, match;
  logic [AW-1:0] wr_word;
  logic [BW-1:0] wr_bit;
  assign idle_or_done = state == IDLE || state == DONE;
  assign go = bus.ena && !bus.abort && bus.arm && idle_or_done;
  assign cap_we = bus.ena && !bus.abort && state == CAPTURE && bus.sin_valid;
  assign last = bus.bit_count == BCW'(TOTAL - 1);
  assign wr_word = AW'(bus.bit_count / BCW'(WIDTH));
  assign wr_bit = BW'(bus.bit_count % BCW'(WIDTH));
`ifdef SERIAL_CAPTURE_TRIGGER_EN
  localparam state_t START = ARMED;
  serial_capture_trigger #(.WIDTH(WIDTH)) u_trig (
    .clk(clk),
    .rst_n(rst_n),
    .clear(go),
    .shift(bus.ena && !bus.abort && state == ARMED && bus.sin_valid),
    .sin(bus.sin),
    .pattern(bus.trig_pattern),
    .match(match)
  );
`else
  localparam state_t START = CAPTURE;
  logic unused_pattern;
  assign unused_pattern = ^bus.trig_pattern;
  assign match = 1'b0;
`endif
  // capture FSM with registered busy/done; abort outranks arm, ena low holds everything
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bus.bit_count <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else if (bus.ena) begin
      if (bus.abort) begin
        state <= IDLE;
        bus.busy <= 1'b0;
        bus.done <= 1'b0;
      end else if (go) begin
        state <= START;
        bus.bit_count <= '0;
        bus.busy <= 1'b1;
        bus.done <= 1'b0;
      end else if (state == ARMED && bus.sin_valid && match) begin
        state <= CAPTURE;
      end else if (cap_we) begin
        bus.bit_count <= bus.bit_count + BCW'(1);
        state <= last ? DONE : CAPTURE;
        bus.busy <= !last;
        bus.done <= last;
      end
    end
  // storage: one bit per captured cycle, first bit lands in word 0 bit 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (cap_we) begin
      mem[wr_word][wr_bit] <= bus.sin;
    end
  // registered readback, served regardless of ena or FSM state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.rd_data <= '0;
    else bus.rd_data <= mem[bus.rd_addr];
endmodule

// File: tb/tb_serial_capture_buffer.sv
// tb_serial_capture_buffer: directed self-checking bench for serial_capture_buffer (both trigger builds)
module tb_serial_capture_buffer;
  logic clk = 0;
  logic rst_n = 0;
  int total = 0;
  int bad = 0;
  logic [7:0] g [8] = '{8'h96, 8'h4B, 8'hE1, 8'h72, 8'h39, 8'hC8, 8'h0D, 8'hF4};
  logic [7:0] wd;

  serial_capture_buffer_if #(.WIDTH(8), .DEPTH(8)) bus ();
  serial_capture_buffer #(.WIDTH(8), .DEPTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic v);
    bus.sin = b;
    bus.sin_valid = v;
    tick();
    bus.sin_valid = 0;
  endtask

  task automatic send_lsb(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1);
  endtask

  task automatic send_msb(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i], 1);
  endtask

  task automatic arm_only();
    bus.arm = 1;
    bus.sin = 1;
    bus.sin_valid = 1;
    tick();
    bus.arm = 0;
    bus.sin_valid = 0;
  endtask

  task automatic start();
    arm_only();
`ifdef SERIAL_CAPTURE_TRIGGER_EN
    send_msb(8'h3C);
`endif
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [7:0] exp, input string tag);
    bus.rd_addr = a;
    tick();
    chk(bus.rd_data, exp, tag);
  endtask

  initial begin
    bus.ena = 1;
    bus.sin = 0;
    bus.sin_valid = 0;
    bus.arm = 0;
    bus.abort = 0;
    bus.trig_pattern = 8'h3C;
    bus.rd_addr = 0;
    tick();
    tick();
    chk(bus.busy, 0, "rst_busy");
    chk(bus.done, 0, "rst_done");
    chk(bus.bit_count, 0, "rst_bc");
    chk(bus.rd_data, 0, "rst_rd");
    rst_n = 1;
    tick();

    start();
    chk(bus.busy, 1, "a5_busy_arm");
    chk(bus.bit_count, 0, "a5_bc_arm");
    for (int k = 0; k < 64; k++) begin
      wd = 8'hA5;
      if (k == 63) chk(bus.done, 0, "a5_done_early");
      send_bit(wd[k % 8], 1);
    end
    chk(bus.done, 1, "a5_done");
    chk(bus.busy, 0, "a5_busy_end");
    chk(bus.bit_count, 64, "a5_bc");
    for (int a = 0; a < 8; a++) rd_chk(3'(a), 8'hA5, "a5_rd");

    start();
    for (int k = 0; k < 64; k++) begin
      wd = g[k / 8];
      if (k == 63) begin
        chk(bus.done, 0, "gap_done_early");
        chk(bus.bit_count, 63, "gap_bc63");
      end
      send_bit(wd[k % 8], 1);
      if (k == 63) begin
        chk(bus.done, 1, "gap_done");
        chk(bus.bit_count, 64, "gap_bc");
      end
      send_bit(~wd[k % 8], 0);
    end
    for (int a = 0; a < 8; a++) rd_chk(3'(a), g[a], "gap_rd");

`ifdef SERIAL_CAPTURE_TRIGGER_EN
    arm_only();
    send_msb(8'h00);
    chk(bus.busy, 1, "trg_armed_busy");
    send_msb(8'h3C);
    chk(bus.bit_count, 0, "trg_bc_pattern");
    for (int i = 1; i <= 8; i++) send_lsb(8'(i * 8'h11));
    chk(bus.done, 1, "trg_done");
    rd_chk(0, 8'h11, "trg_w0");
    rd_chk(7, 8'h88, "trg_w7");
`endif

    start();
    send_lsb(8'h5A);
    send_lsb(8'hC3);
    for (int i = 0; i < 4; i++) send_bit(i == 0 || i == 3, 1);
    bus.abort = 1;
    tick();
    bus.abort = 0;
    chk(bus.busy, 0, "abt_busy");
    chk(bus.done, 0, "abt_done");
    chk(bus.bit_count, 20, "abt_bc");
    rd_chk(0, 8'h5A, "abt_w0");
    rd_chk(1, 8'hC3, "abt_w1");
`ifdef SERIAL_CAPTURE_TRIGGER_EN
    rd_chk(2, 8'h39, "abt_w2");
`else
    rd_chk(2, 8'hE9, "abt_w2");
`endif

    bus.arm = 1;
    bus.abort = 1;
    tick();
    bus.arm = 0;
    bus.abort = 0;
    chk(bus.busy, 0, "armabt_busy");
    chk(bus.bit_count, 20, "armabt_bc");

    start();
    for (int i = 0; i < 10; i++) send_bit(1, 1);
    bus.arm = 1;
    send_bit(1, 1);
    bus.arm = 0;
    chk(bus.busy, 1, "rearm_busy");
    chk(bus.bit_count, 11, "rearm_bc");
    bus.ena = 0;
    bus.sin = 0;
    bus.sin_valid = 1;
    tick();
    tick();
    tick();
    bus.sin_valid = 0;
    chk(bus.bit_count, 11, "ena_hold_bc");
    rd_chk(0, 8'hFF, "ena_rd_w0");
    rd_chk(1, 8'hC7, "ena_rd_w1");
    bus.ena = 1;
    bus.rd_addr = 0;
    for (int i = 0; i < 19; i++) send_bit(1, 1);
    chk(bus.bit_count, 30, "pre_rst_bc");
    chk(bus.rd_data, 8'hFF, "pre_rst_rd");
    #2 rst_n = 0;
    #1;
    chk(bus.busy, 0, "arst_busy");
    chk(bus.done, 0, "arst_done");
    chk(bus.bit_count, 0, "arst_bc");
    chk(bus.rd_data, 0, "arst_rd");
    tick();
    rst_n = 1;
    for (int a = 0; a < 8; a++) rd_chk(3'(a), 8'h00, "arst_mem");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
